pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter CNT_W, default 16, width of the performance counters.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 ID_RS1, ID_RS2  input  5 each  source register indices of the instruction in ID.
REQ-005 ID_USES_RS1, ID_USES_RS2  input  1 each  ID instruction actually reads that source.
REQ-006 EX_RD  input  5  destination index in EX (ID_EX register output).
REQ-007 EX_MEM_READ  input  1  EX instruction is a load.
REQ-008 EX_BRANCH_TAKEN  input  1  branch/jump resolved taken in EX.
REQ-009 EX_MC_START  input  1  EX holds a multicycle (mul/div) op; EX_MC_DONE  input  1  its result is valid this cycle.
REQ-010 IMEM_BUSYWAIT, DMEM_BUSYWAIT  input  1 each  memory not ready.
REQ-011 CNT_CLEAR  input  1  synchronous counter clear.
REQ-012 PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD  output  1 each  register keeps its value this edge.
REQ-013 IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE  output  1 each  register loads a NOP (all control bits 0) this edge.
REQ-014 STATE  output  2  RUN=0, MC_WAIT=1, MEM_WAIT=2.
REQ-015 STALL_CYCLES, FLUSH_COUNT  output  CNT_W each  performance counters.

Function
REQ-016 Hold/flush outputs SHALL be combinational from STATE and current inputs (same-cycle response); STATE and counters SHALL be registered.
REQ-017 Priority, highest first: memory freeze, multicycle wait, branch flush, load-use stall.
REQ-018 Memory freeze: IMEM_BUSYWAIT or DMEM_BUSYWAIT high -> all five HOLD outputs 1, all FLUSH/BUBBLE outputs 0, counters except STALL_CYCLES unchanged.
REQ-019 On first freeze cycle the FSM SHALL record the pre-freeze state (RUN or MC_WAIT) and enter MEM_WAIT; when both busywaits are low it SHALL return to the recorded state the next edge.
REQ-020 MC_WAIT entry: in RUN, EX_MC_START=1 and EX_MC_DONE=0 -> next state MC_WAIT.
REQ-021 While multicycle pending (MC_WAIT, or RUN with EX_MC_START=1 and EX_MC_DONE=0): PC_HOLD, IF_ID_HOLD, ID_EX_HOLD = 1; EX_MEM_BUBBLE = 1; MEM_WB advances.
REQ-022 EX_MC_DONE=1 (any state, no freeze) -> no multicycle holds that cycle; next state RUN.
REQ-023 Branch flush (RUN, EX_BRANCH_TAKEN=1): IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_HOLD=0; FLUSH_COUNT +1; overrides load-use stall.
REQ-024 Load-use hazard: EX_MEM_READ=1, EX_RD!=0, and (ID_USES_RS1 and ID_RS1==EX_RD or ID_USES_RS2 and ID_RS2==EX_RD) -> PC_HOLD=1, IF_ID_HOLD=1, ID_EX_BUBBLE=1 for exactly that cycle; no state change.
REQ-025 A branch in EX during freeze or MC_WAIT SHALL be acted on in the first cycle after release (inputs remain stable because EX is held).
REQ-026 STALL_CYCLES SHALL increment on every edge where PC_HOLD=1 and no branch flush; FLUSH_COUNT per REQ-023.
REQ-027 Counters SHALL saturate at all-ones; CNT_CLEAR=1 SHALL zero both on the next edge, overriding increment.
REQ-028 No hazard, no wait: all HOLD/FLUSH/BUBBLE outputs 0.

Reset
REQ-029 RESET low SHALL immediately force STATE=RUN, recorded state=RUN, both counters 0, all HOLD/FLUSH/BUBBLE outputs 0, regardless of CLK.
REQ-030 Reset asserted mid-MC_WAIT or mid-MEM_WAIT SHALL abandon the pending operation; first edge after release evaluates from RUN.

Structure
REQ-031 State encodings and CNT_W default SHALL live in shared package pipeline_ctrl_pkg.
REQ-032 Hazard comparison SHALL be a sub-module load_use_detector (purely combinational); FSM, priority logic and counters in the top.

Verification
REQ-033 Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 -> one cycle PC_HOLD=IF_ID_HOLD=ID_EX_BUBBLE=1, STALL_CYCLES 0->1; same with EX_RD=0 -> no stall.
REQ-034 Branch plus load-use same cycle: EX_BRANCH_TAKEN=1 with REQ-033 hazard -> IF_ID_FLUSH=ID_EX_BUBBLE=1, PC_HOLD=0, FLUSH_COUNT=1, STALL_CYCLES unchanged.
REQ-035 Multicycle: EX_MC_START=1 for 4 cycles, EX_MC_DONE on 4th -> STATE 0,1,1,1,0; EX_MEM_BUBBLE=1 for cycles 1-3; STALL_CYCLES=3.
REQ-036 Freeze inside MC_WAIT: DMEM_BUSYWAIT=1 for 2 cycles during MC_WAIT -> STATE MEM_WAIT for 2 cycles, all HOLD=1, then returns to MC_WAIT.
REQ-037 Saturation/clear: CNT_W=4, 20 stall cycles -> STALL_CYCLES=15; CNT_CLEAR=1 -> 0 next edge.
REQ-038 Async reset: RESET low mid-MC_WAIT between edges -> STATE=0 and outputs 0 before next CLK edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings are visible on the STATE output, so the values are fixed.
package pipeline_ctrl_pkg;

   localparam int unsigned CntWDefault = 16;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMcWait  = 2'd1,
      StMemWait = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic pc_hold;
      logic if_id_hold;
      logic id_ex_hold;
      logic ex_mem_hold;
      logic mem_wb_hold;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_bubble;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t PipeCtrlNone = '0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detector: a load in EX writing a register
// that the instruction in ID actually reads. x0 never creates a hazard.
module load_use_detector (
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   output logic       hazard_o
);

   logic rd_nonzero;
   logic rs1_match;
   logic rs2_match;

   always_comb begin
      rd_nonzero = (ex_rd_i != 5'd0);
      rs1_match  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
      rs2_match  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
      hazard_o   = ex_mem_read_i && rd_nonzero && (rs1_match || rs2_match);
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline hazard controller: memory freeze, multicycle wait,
// branch flush and load-use stall, with saturating performance counters.
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_branch_taken_i,
   input  logic             ex_mc_start_i,
   input  logic             ex_mc_done_i,
   input  logic             imem_busywait_i,
   input  logic             dmem_busywait_i,
   input  logic             cnt_clear_i,
   output logic             pc_hold_o,
   output logic             if_id_hold_o,
   output logic             id_ex_hold_o,
   output logic             ex_mem_hold_o,
   output logic             mem_wb_hold_o,
   output logic             if_id_flush_o,
   output logic             id_ex_bubble_o,
   output logic             ex_mem_bubble_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   ctrl_state_e      state_q, state_d;
   ctrl_state_e      saved_q, saved_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic        load_use;
   logic        freeze;
   ctrl_state_e eff_state;
   logic        mc_pending;
   logic        br_flush;
   pipe_ctrl_t  ctrl;

   load_use_detector u_load_use_detector (
      .ex_mem_read_i (ex_mem_read_i),
      .ex_rd_i       (ex_rd_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_uses_rs1_i (id_uses_rs1_i),
      .id_uses_rs2_i (id_uses_rs2_i),
      .hazard_o      (load_use)
   );

   // Once memory releases, the cycle behaves as the state that was frozen.
   always_comb begin
      freeze     = imem_busywait_i || dmem_busywait_i;
      eff_state  = (state_q == StMemWait) ? saved_q : state_q;
      mc_pending = !ex_mc_done_i &&
                   ((eff_state == StMcWait) || ((eff_state == StRun) && ex_mc_start_i));
   end

   always_comb begin
      ctrl     = PipeCtrlNone;
      br_flush = 1'b0;
      if (!rst_ni) begin
         ctrl = PipeCtrlNone;
      end else if (freeze) begin
         ctrl.pc_hold     = 1'b1;
         ctrl.if_id_hold  = 1'b1;
         ctrl.id_ex_hold  = 1'b1;
         ctrl.ex_mem_hold = 1'b1;
         ctrl.mem_wb_hold = 1'b1;
      end else if (mc_pending) begin
         ctrl.pc_hold       = 1'b1;
         ctrl.if_id_hold    = 1'b1;
         ctrl.id_ex_hold    = 1'b1;
         ctrl.ex_mem_bubble = 1'b1;
      end else if (ex_branch_taken_i) begin
         ctrl.if_id_flush  = 1'b1;
         ctrl.id_ex_bubble = 1'b1;
         br_flush          = 1'b1;
      end else if (load_use) begin
         ctrl.pc_hold      = 1'b1;
         ctrl.if_id_hold   = 1'b1;
         ctrl.id_ex_bubble = 1'b1;
      end
   end

   always_comb begin
      pc_hold_o       = ctrl.pc_hold;
      if_id_hold_o    = ctrl.if_id_hold;
      id_ex_hold_o    = ctrl.id_ex_hold;
      ex_mem_hold_o   = ctrl.ex_mem_hold;
      mem_wb_hold_o   = ctrl.mem_wb_hold;
      if_id_flush_o   = ctrl.if_id_flush;
      id_ex_bubble_o  = ctrl.id_ex_bubble;
      ex_mem_bubble_o = ctrl.ex_mem_bubble;
      state_o         = state_q;
      stall_cycles_o  = stall_q;
      flush_count_o   = flush_q;
   end

   // Only RUN or MC_WAIT is ever recorded; a freeze extending MEM_WAIT keeps it.
   always_comb begin
      state_d = state_q;
      saved_d = saved_q;
      if (freeze) begin
         if (state_q != StMemWait) begin
            saved_d = state_q;
         end
         state_d = StMemWait;
      end else if (ex_mc_done_i) begin
         state_d = StRun;
      end else if (mc_pending) begin
         state_d = StMcWait;
      end else begin
         state_d = StRun;
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (cnt_clear_i) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         if (ctrl.pc_hold && !br_flush && (stall_q != '1)) begin
            stall_d = stall_q + CntOne;
         end
         if (br_flush && (flush_q != '1)) begin
            flush_d = flush_q + CntOne;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StRun;
         saved_q <= StRun;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: single-cycle vector table plus multicycle, freeze,
// saturation and asynchronous reset sequences.
module tb_pipeline_hazard_controller;

   logic       clk;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic       ex_mc_start, ex_mc_done, imem_busywait, dmem_busywait, cnt_clear;

   logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold;
   logic        if_id_flush, id_ex_bubble, ex_mem_bubble;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;

   logic        pc_hold4, if_id_hold4, id_ex_hold4, ex_mem_hold4, mem_wb_hold4;
   logic        if_id_flush4, id_ex_bubble4, ex_mem_bubble4;
   logic [1:0]  state4;
   logic [3:0]  stall_cnt4, flush_cnt4;

   logic [7:0] ctrl;
   logic [7:0] ctrl4;
   assign ctrl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold,
                  if_id_flush, id_ex_bubble, ex_mem_bubble};
   assign ctrl4 = {pc_hold4, if_id_hold4, id_ex_hold4, ex_mem_hold4, mem_wb_hold4,
                   if_id_flush4, id_ex_bubble4, ex_mem_bubble4};

   int n_tests = 0;
   int n_fail  = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipeline_hazard_controller u_dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .id_rs1_i          (id_rs1),
      .id_rs2_i          (id_rs2),
      .id_uses_rs1_i     (id_uses_rs1),
      .id_uses_rs2_i     (id_uses_rs2),
      .ex_rd_i           (ex_rd),
      .ex_mem_read_i     (ex_mem_read),
      .ex_branch_taken_i (ex_branch_taken),
      .ex_mc_start_i     (ex_mc_start),
      .ex_mc_done_i      (ex_mc_done),
      .imem_busywait_i   (imem_busywait),
      .dmem_busywait_i   (dmem_busywait),
      .cnt_clear_i       (cnt_clear),
      .pc_hold_o         (pc_hold),
      .if_id_hold_o      (if_id_hold),
      .id_ex_hold_o      (id_ex_hold),
      .ex_mem_hold_o     (ex_mem_hold),
      .mem_wb_hold_o     (mem_wb_hold),
      .if_id_flush_o     (if_id_flush),
      .id_ex_bubble_o    (id_ex_bubble),
      .ex_mem_bubble_o   (ex_mem_bubble),
      .state_o           (state),
      .stall_cycles_o    (stall_cnt),
      .flush_count_o     (flush_cnt)
   );

   pipeline_hazard_controller #(.CNT_W(4)) u_dut4 (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .id_rs1_i          (id_rs1),
      .id_rs2_i          (id_rs2),
      .id_uses_rs1_i     (id_uses_rs1),
      .id_uses_rs2_i     (id_uses_rs2),
      .ex_rd_i           (ex_rd),
      .ex_mem_read_i     (ex_mem_read),
      .ex_branch_taken_i (ex_branch_taken),
      .ex_mc_start_i     (ex_mc_start),
      .ex_mc_done_i      (ex_mc_done),
      .imem_busywait_i   (imem_busywait),
      .dmem_busywait_i   (dmem_busywait),
      .cnt_clear_i       (cnt_clear),
      .pc_hold_o         (pc_hold4),
      .if_id_hold_o      (if_id_hold4),
      .id_ex_hold_o      (id_ex_hold4),
      .ex_mem_hold_o     (ex_mem_hold4),
      .mem_wb_hold_o     (mem_wb_hold4),
      .if_id_flush_o     (if_id_flush4),
      .id_ex_bubble_o    (id_ex_bubble4),
      .ex_mem_bubble_o   (ex_mem_bubble4),
      .state_o           (state4),
      .stall_cycles_o    (stall_cnt4),
      .flush_count_o     (flush_cnt4)
   );

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, br, mcs, mcd, ib, db;
      logic [7:0] exp_ctrl;
      logic [1:0] exp_st;
      int         stall_inc;
      int         flush_inc;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u1, input logic u2,
                               input logic mr, input logic br, input logic mcs,
                               input logic mcd, input logic ib, input logic db,
                               input logic [7:0] exp_ctrl, input logic [1:0] exp_st,
                               input int stall_inc, input int flush_inc);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2; v.mr = mr;
      v.br = br; v.mcs = mcs; v.mcd = mcd; v.ib = ib; v.db = db;
      v.exp_ctrl = exp_ctrl; v.exp_st = exp_st;
      v.stall_inc = stall_inc; v.flush_inc = flush_inc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; ex_mc_start = 1'b0; ex_mc_done = 1'b0;
      imem_busywait = 1'b0; dmem_busywait = 1'b0; cnt_clear = 1'b0;
   endtask

   task automatic clear_counters();
      clear_inputs();
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      check("clear stall", stall_cnt, 0);
      check("clear flush", flush_cnt, 0);
   endtask

   task automatic set_hazard();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
   endtask

   initial begin
      //                  rs1    rs2    rd     u1 u2 mr br mcs mcd ib db ctrl      st  s  f
      vecs[0]  = mk(5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0,  0,  0, 0, 8'b00000000, 0, 0, 0);
      vecs[1]  = mk(5'd0,  5'd5,  5'd5,  0, 1, 1, 0, 0,  0,  0, 0, 8'b11000010, 0, 1, 0);
      vecs[2]  = mk(5'd0,  5'd0,  5'd0,  0, 1, 1, 0, 0,  0,  0, 0, 8'b00000000, 0, 0, 0);
      vecs[3]  = mk(5'd7,  5'd1,  5'd7,  1, 0, 1, 0, 0,  0,  0, 0, 8'b11000010, 0, 1, 0);
      vecs[4]  = mk(5'd7,  5'd1,  5'd7,  0, 1, 1, 0, 0,  0,  0, 0, 8'b00000000, 0, 0, 0);
      vecs[5]  = mk(5'd7,  5'd7,  5'd7,  1, 1, 0, 0, 0,  0,  0, 0, 8'b00000000, 0, 0, 0);
      vecs[6]  = mk(5'd0,  5'd5,  5'd5,  0, 1, 1, 1, 0,  0,  0, 0, 8'b00000110, 0, 0, 1);
      vecs[7]  = mk(5'd3,  5'd4,  5'd9,  1, 1, 0, 1, 0,  0,  0, 0, 8'b00000110, 0, 0, 1);
      vecs[8]  = mk(5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 1,  1,  0, 0, 8'b00000000, 0, 0, 0);
      vecs[9]  = mk(5'd0,  5'd5,  5'd5,  0, 1, 1, 1, 0,  0,  0, 1, 8'b11111000, 2, 1, 0);
      vecs[10] = mk(5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0,  0,  0, 0, 8'b00000000, 0, 0, 0);
      vecs[11] = mk(5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 0,  0,  1, 0, 8'b11111000, 2, 1, 0);
      vecs[12] = mk(5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 0,  0,  0, 0, 8'b00000110, 0, 0, 1);
      vecs[13] = mk(5'd31, 5'd31, 5'd31, 1, 1, 1, 0, 0,  0,  0, 0, 8'b11000010, 0, 1, 0);

      clear_inputs();
      rst_n = 1'b0;
      #2;
      check("reset ctrl", ctrl, 0);
      check("reset state", state, 0);
      check("reset stall", stall_cnt, 0);
      check("reset flush", flush_cnt, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
         id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; ex_mem_read = vecs[i].mr;
         ex_branch_taken = vecs[i].br; ex_mc_start = vecs[i].mcs; ex_mc_done = vecs[i].mcd;
         imem_busywait = vecs[i].ib; dmem_busywait = vecs[i].db;
         #2;
         check($sformatf("vec%0d ctrl", i), ctrl, vecs[i].exp_ctrl);
         tick();
         exp_stall += vecs[i].stall_inc;
         exp_flush += vecs[i].flush_inc;
         check($sformatf("vec%0d state", i), state, vecs[i].exp_st);
         check($sformatf("vec%0d stall", i), stall_cnt, exp_stall);
         check($sformatf("vec%0d flush", i), flush_cnt, exp_flush);
      end

      // Multicycle op held in EX for four cycles, done on the fourth.
      clear_counters();
      for (int c = 0; c < 4; c++) begin
         ex_mc_start = 1'b1;
         ex_mc_done  = (c == 3);
         #2;
         check($sformatf("mc%0d state", c), state, (c == 0) ? 0 : 1);
         check($sformatf("mc%0d ex_mem_bubble", c), ex_mem_bubble, (c < 3) ? 1 : 0);
         check($sformatf("mc%0d pc_hold", c), pc_hold, (c < 3) ? 1 : 0);
         check($sformatf("mc%0d mem_wb_hold", c), mem_wb_hold, 0);
         tick();
      end
      check("mc end state", state, 0);
      check("mc stall", stall_cnt, 3);

      // Two-cycle data memory freeze while in MC_WAIT.
      clear_counters();
      ex_mc_start = 1'b1;
      tick();
      check("frz enter mc", state, 1);
      dmem_busywait = 1'b1;
      #2;
      check("frz c1 ctrl", ctrl, 8'b11111000);
      tick();
      check("frz c1 state", state, 2);
      #2;
      check("frz c2 ctrl", ctrl, 8'b11111000);
      tick();
      check("frz c2 state", state, 2);
      dmem_busywait = 1'b0;
      #2;
      check("frz release ctrl", ctrl, 8'b11100001);
      tick();
      check("frz back to mc", state, 1);
      ex_mc_done = 1'b1;
      #2;
      check("frz done ctrl", ctrl, 0);
      tick();
      check("frz done state", state, 0);
      check("frz stall", stall_cnt, 4);

      // Saturation on the narrow instance, then clear overriding increment.
      clear_counters();
      set_hazard();
      for (int c = 0; c < 20; c++) tick();
      check("sat stall4", stall_cnt4, 15);
      check("sat stall16", stall_cnt, 20);
      cnt_clear = 1'b1;
      tick();
      check("clr stall4", stall_cnt4, 0);
      check("clr stall16", stall_cnt, 0);
      cnt_clear = 1'b0;

      // Asynchronous reset between edges while in MC_WAIT.
      clear_inputs();
      ex_mc_start = 1'b1;
      tick();
      check("rst pre state", state, 1);
      #2;
      check("rst pre pc_hold", pc_hold, 1);
      rst_n = 1'b0;
      #1;
      check("rst async state", state, 0);
      check("rst async ctrl", ctrl, 0);
      check("rst async stall", stall_cnt, 0);
      ex_mc_start = 1'b0;
      #1 rst_n = 1'b1;
      tick();
      check("rst evaluates from run", state, 0);
      check("rst post ctrl", ctrl, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
